// File: rtl/centroid_pkg.sv
// Shared types and constants for the centroid divide scheduler and its divider.
package centroid_pkg;

  localparam int DEF_ACC_W   = 32;
  localparam int DEF_COORD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  // Bit 1 of the job index selects the colour: 0 = pink, 1 = green.
  localparam logic [1:0] JOB_PX = 2'd0;
  localparam logic [1:0] JOB_PY = 2'd1;
  localparam logic [1:0] JOB_GX = 2'd2;
  localparam logic [1:0] JOB_GY = 2'd3;

endpackage

// File: rtl/centroid_seq_div.sv
// Restoring unsigned divider, one quotient bit per cycle; div_done pulses ACC_W
// cycles after div_start. A new div_start restarts it.
module centroid_seq_div #(
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_start,
  input  logic [ACC_W-1:0] numer,
  input  logic [ACC_W-1:0] denom,
  output logic [ACC_W-1:0] quotient,
  output logic             div_done
);

  localparam int CNT_W = $clog2(ACC_W + 1);

  logic [ACC_W-1:0] rem_q, rem_d;
  logic [ACC_W-1:0] quo_q, quo_d;
  logic [ACC_W-1:0] den_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;
  logic             done_q;

  logic [ACC_W-1:0] rem_in, quo_in, den_in;
  logic [ACC_W:0]   rem_sh;
  logic [ACC_W:0]   diff;

  // The start cycle already performs the first step on the fresh operands,
  // so the last bit lands exactly ACC_W cycles later.
  always_comb begin
    rem_in = div_start ? '0    : rem_q;
    quo_in = div_start ? numer : quo_q;
    den_in = div_start ? denom : den_q;
    rem_sh = {rem_in, quo_in[ACC_W-1]};
    diff   = rem_sh - {1'b0, den_in};
    if (!diff[ACC_W]) begin
      rem_d = diff[ACC_W-1:0];
      quo_d = {quo_in[ACC_W-2:0], 1'b1};
    end else begin
      rem_d = rem_sh[ACC_W-1:0];
      quo_d = {quo_in[ACC_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (div_start) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
        den_q <= denom;
        cnt_q <= CNT_W'(ACC_W - 1);
        run_q <= 1'b1;
      end else if (run_q) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo_q;
  assign div_done = done_q;

endmodule

// File: rtl/centroid_div_scheduler.sv
// Frame-end scheduler: snapshots pink/green accumulators and runs four centroid
// divisions through one shared divider, publishing all results at once.
//
// state     | meaning
// ST_IDLE   | waiting for frame_end; snapshot taken on acceptance
// ST_ISSUE  | start current job's division, or skip it if colour not found
// ST_WAIT   | divider running for current job
// ST_FINISH | publish coordinates and found flags, pulse centers_valid
module centroid_div_scheduler
  import centroid_pkg::*;
#(
  parameter int ACC_W      = DEF_ACC_W,
  parameter int COORD_W    = DEF_COORD_W,
  parameter int MIN_PIXELS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_end,
  input  logic [ACC_W-1:0]   pink_x_acc,
  input  logic [ACC_W-1:0]   pink_y_acc,
  input  logic [ACC_W-1:0]   pink_cnt,
  input  logic [ACC_W-1:0]   green_x_acc,
  input  logic [ACC_W-1:0]   green_y_acc,
  input  logic [ACC_W-1:0]   green_cnt,
  output logic               busy,
  output logic               centers_valid,
  output logic [COORD_W-1:0] pink_cx,
  output logic [COORD_W-1:0] pink_cy,
  output logic [COORD_W-1:0] green_cx,
  output logic [COORD_W-1:0] green_cy,
  output logic               pink_found,
  output logic               green_found,
  output logic               overrun
);

  localparam logic [ACC_W-1:0] COORD_MAX = ACC_W'({COORD_W{1'b1}});
  localparam logic [ACC_W-1:0] MIN_CNT   = ACC_W'(MIN_PIXELS);

  state_e             state_q;
  logic [1:0]         job_q;
  logic [ACC_W-1:0]   px_q, py_q, pcnt_q, gx_q, gy_q, gcnt_q;
  logic [COORD_W-1:0] tmp_q [4];
  logic [COORD_W-1:0] tmp_d [4];
  logic [COORD_W-1:0] pink_cx_q, pink_cy_q, green_cx_q, green_cy_q;
  logic               pink_found_q, green_found_q;
  logic               valid_q, overrun_q;

  logic [ACC_W-1:0]   job_acc, job_cnt;
  logic               snap_pf, snap_gf, job_found, last_job;
  logic               div_start, div_done, job_end;
  logic [ACC_W-1:0]   div_quo;
  logic [COORD_W-1:0] quo_sat;
  logic               tmp_we;
  logic [COORD_W-1:0] tmp_wval;

  always_comb begin
    case (job_q)
      JOB_PX:  job_acc = px_q;
      JOB_PY:  job_acc = py_q;
      JOB_GX:  job_acc = gx_q;
      default: job_acc = gy_q;
    endcase
    job_cnt   = job_q[1] ? gcnt_q : pcnt_q;
    snap_pf   = pcnt_q >= MIN_CNT;
    snap_gf   = gcnt_q >= MIN_CNT;
    job_found = job_q[1] ? snap_gf : snap_pf;
    last_job  = job_q == JOB_GY;
    div_start = (state_q == ST_ISSUE) && job_found;
    quo_sat   = (div_quo > COORD_MAX) ? '1 : div_quo[COORD_W-1:0];
  end

  // A skipped job writes 0; a computed job writes the saturated quotient.
  always_comb begin
    tmp_we   = 1'b0;
    tmp_wval = '0;
    if (state_q == ST_ISSUE && !job_found) begin
      tmp_we = 1'b1;
    end else if (state_q == ST_WAIT && div_done) begin
      tmp_we   = 1'b1;
      tmp_wval = quo_sat;
    end
    job_end = tmp_we;
    for (int i = 0; i < 4; i++) begin
      tmp_d[i] = (tmp_we && job_q == 2'(i)) ? tmp_wval : tmp_q[i];
    end
  end

  centroid_seq_div #(
    .ACC_W(ACC_W)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .div_start (div_start),
    .numer     (job_acc),
    .denom     (job_cnt),
    .quotient  (div_quo),
    .div_done  (div_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      job_q         <= JOB_PX;
      px_q          <= '0;
      py_q          <= '0;
      pcnt_q        <= '0;
      gx_q          <= '0;
      gy_q          <= '0;
      gcnt_q        <= '0;
      tmp_q         <= '{default: '0};
      pink_cx_q     <= '0;
      pink_cy_q     <= '0;
      green_cx_q    <= '0;
      green_cy_q    <= '0;
      pink_found_q  <= 1'b0;
      green_found_q <= 1'b0;
      valid_q       <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      overrun_q <= frame_end && (state_q != ST_IDLE);
      tmp_q     <= tmp_d;
      case (state_q)
        ST_IDLE: begin
          if (frame_end) begin
            px_q    <= pink_x_acc;
            py_q    <= pink_y_acc;
            pcnt_q  <= pink_cnt;
            gx_q    <= green_x_acc;
            gy_q    <= green_y_acc;
            gcnt_q  <= green_cnt;
            job_q   <= JOB_PX;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE, ST_WAIT: begin
          if (div_start) begin
            state_q <= ST_WAIT;
          end else if (job_end) begin
            if (last_job) begin
              // Publish on entry so the outputs change in the same cycle as valid.
              state_q       <= ST_FINISH;
              pink_cx_q     <= tmp_d[JOB_PX];
              pink_cy_q     <= tmp_d[JOB_PY];
              green_cx_q    <= tmp_d[JOB_GX];
              green_cy_q    <= tmp_d[JOB_GY];
              pink_found_q  <= snap_pf;
              green_found_q <= snap_gf;
              valid_q       <= 1'b1;
            end else begin
              job_q   <= job_q + 2'd1;
              state_q <= ST_ISSUE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy          = state_q != ST_IDLE;
  assign centers_valid = valid_q;
  assign overrun       = overrun_q;
  assign pink_cx       = pink_cx_q;
  assign pink_cy       = pink_cy_q;
  assign green_cx      = green_cx_q;
  assign green_cy      = green_cy_q;
  assign pink_found    = pink_found_q;
  assign green_found   = green_found_q;

endmodule
